// File: rtl/led_pkg.sv
// Shared panel constants, scan-state encoding and pixel type for the 64x64 HUB75 pong display.
// Also provides the checkerboard word used by the LED_SCAN_TEST_EN build.
package led_pkg;

    localparam int WIDTH     = 64;
    localparam int HEIGHT    = 64;
    localparam int SCAN_ROWS = 32;

    typedef enum logic [2:0] {
        FETCH_U,
        FETCH_L,
        WAIT_L,
        SHIFT,
        BLANK,
        LATCH,
        SHOW
    } state_t;

    typedef logic [2:0] rgb_t;

    // pixel(c) = (c ^ row) bit 0, so only the row parity matters
    function automatic logic [WIDTH-1:0] checker_word(input logic row_lsb);
        return row_lsb ? {(WIDTH/2){2'b01}} : {(WIDTH/2){2'b10}};
    endfunction

endpackage

// File: rtl/led_row_shifter.sv
// Holds the upper and lower half-row words and walks the column index from 63 down to 0.
// The lower word is presented straight from the load bus in the cycle it is captured.
module led_row_shifter
    import led_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_up,
    input  logic             load_lo,
    input  logic [WIDTH-1:0] word,
    input  logic             adv,
    output logic             bit_up,
    output logic             bit_lo,
    output logic             done
);

    logic [WIDTH-1:0] up_word;
    logic [WIDTH-1:0] lo_word;
    logic [5:0]       col;
    logic             done_r;

    always_ff @(posedge clk) begin
        if (load_up) up_word <= word;
        if (load_lo) lo_word <= word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= 6'd63;
            done_r <= 1'b0;
        end else if (load_up) begin
            col    <= 6'd63;
            done_r <= 1'b0;
        end else if (adv) begin
            col <= col - 6'd1;
            if (col == 6'd0) done_r <= 1'b1;
        end
    end

    // first slot of a row coincides with the lower-word capture
    assign bit_up = up_word[col];
    assign bit_lo = load_lo ? word[col] : lo_word[col];
    assign done   = done_r;

endmodule

// File: rtl/led_scan.sv
// Frame-buffer reader and 1/32-scan HUB75 driver; every output is registered.
// Optional build macro LED_SCAN_TEST_EN adds a test_en input that replaces fetched rows with a checkerboard.
module led_scan
    import led_pkg::*;
#(
    parameter int   CLK_DIV   = 2,
    parameter int   ON_CYCLES = 256,
    parameter rgb_t COLOR     = 3'b111
) (
    input  logic        clk,
    input  logic        rst,
`ifdef LED_SCAN_TEST_EN
    input  logic        test_en,
`endif
    output logic        rd_en,
    output logic [5:0]  rd_row,
    input  logic [63:0] rd_data,
    output logic [2:0]  rgb1,
    output logic [2:0]  rgb2,
    output logic        pclk,
    output logic        lat,
    output logic        oe_n,
    output logic [4:0]  addr,
    output logic        frame_start,
    output logic        frame_done
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int ON_W  = $clog2(ON_CYCLES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(ON_CYCLES - 1);

    state_t           state, state_n;
    logic [4:0]       row, row_n;
    logic [DIV_W-1:0] div, div_n;
    logic             phase, phase_n;
    logic [ON_W-1:0]  on_cnt, on_cnt_n;
    logic             lo_vld;

    logic             rd_en_n, lat_n, oe_n_n, pclk_n, fs_n, fd_n;
    logic [5:0]       rd_row_n;
    logic [4:0]       addr_n;
    rgb_t             rgb1_n, rgb2_n;

    logic             adv, bit_up, bit_lo, shift_done;
    logic [63:0]      src;

`ifdef LED_SCAN_TEST_EN
    logic tmode, tmode_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmode <= 1'b0;
        else     tmode <= tmode_n;
    end

    assign src = tmode ? checker_word(row[0]) : rd_data;
`else
    assign src = rd_data;
`endif

    led_row_shifter u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_up (state == WAIT_L),
        .load_lo (lo_vld),
        .word    (src),
        .adv     (adv),
        .bit_up  (bit_up),
        .bit_lo  (bit_lo),
        .done    (shift_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH_U;
            row         <= 5'd0;
            div         <= '0;
            phase       <= 1'b0;
            on_cnt      <= '0;
            lo_vld      <= 1'b0;
            rd_en       <= 1'b0;
            rd_row      <= 6'd0;
            rgb1        <= 3'b000;
            rgb2        <= 3'b000;
            pclk        <= 1'b0;
            lat         <= 1'b0;
            oe_n        <= 1'b1;
            addr        <= 5'd0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            div         <= div_n;
            phase       <= phase_n;
            on_cnt      <= on_cnt_n;
            lo_vld      <= (state == WAIT_L);
            rd_en       <= rd_en_n;
            rd_row      <= rd_row_n;
            rgb1        <= rgb1_n;
            rgb2        <= rgb2_n;
            pclk        <= pclk_n;
            lat         <= lat_n;
            oe_n        <= oe_n_n;
            addr        <= addr_n;
            frame_start <= fs_n;
            frame_done  <= fd_n;
        end
    end

    always_comb begin
        state_n  = state;
        row_n    = row;
        div_n    = div;
        phase_n  = phase;
        on_cnt_n = on_cnt;
        adv      = 1'b0;
        rd_en_n  = 1'b0;
        rd_row_n = rd_row;
        rgb1_n   = 3'b000;
        rgb2_n   = 3'b000;
        pclk_n   = 1'b0;
        lat_n    = 1'b0;
        oe_n_n   = 1'b1;
        addr_n   = addr;
        fs_n     = 1'b0;
        fd_n     = 1'b0;
`ifdef LED_SCAN_TEST_EN
        tmode_n  = tmode;
`endif

        unique case (state)
            FETCH_U: begin
`ifdef LED_SCAN_TEST_EN
                tmode_n = test_en;
                rd_en_n = !test_en;
`else
                rd_en_n = 1'b1;
`endif
                rd_row_n = {1'b0, row};
                fs_n     = (row == 5'd0);
                state_n  = FETCH_L;
            end
            FETCH_L: begin
`ifdef LED_SCAN_TEST_EN
                rd_en_n = !tmode;
`else
                rd_en_n = 1'b1;
`endif
                rd_row_n = {1'b1, row};
                div_n    = '0;
                phase_n  = 1'b0;
                state_n  = WAIT_L;
            end
            WAIT_L: begin
                state_n = SHIFT;
            end
            SHIFT: begin
                // each slot: new column on pclk low, held through pclk high
                adv    = !phase && (div == '0);
                pclk_n = phase;
                rgb1_n = adv ? (bit_up ? COLOR : 3'b000) : rgb1;
                rgb2_n = adv ? (bit_lo ? COLOR : 3'b000) : rgb2;
                if (div == DIV_LAST) begin
                    div_n   = '0;
                    phase_n = !phase;
                    if (phase && shift_done) state_n = BLANK;
                end else begin
                    div_n = div + 1'b1;
                end
            end
            BLANK: begin
                addr_n   = row;
                on_cnt_n = '0;
                state_n  = LATCH;
            end
            LATCH: begin
                lat_n   = 1'b1;
                state_n = SHOW;
            end
            SHOW: begin
                oe_n_n = 1'b0;
                if (on_cnt == ON_LAST) begin
                    fd_n    = (row == 5'd31);
                    row_n   = row + 5'd1;
                    state_n = FETCH_U;
                end else begin
                    on_cnt_n = on_cnt + 1'b1;
                end
            end
            default: state_n = FETCH_U;
        endcase
    end

endmodule

// File: doc/led_scan.md
# led_scan

Frame-buffer reader and HUB75 driver for the 64x64 single-bit pong display. It reads the frame assembled by the game/render logic one 64-pixel row word at a time over a synchronous read port. It serializes upper and lower half-rows into a 1/32-scan HUB75 panel and generates the pixel clock, latch, output-enable and row address. It also emits frame-boundary pulses so game logic can update positions between scans.

## Interface
- `CLK_DIV`, 2: pclk half-period in clk cycles (≥1).
- `ON_CYCLES`, 256: clk cycles oe_n is held low per scan row (≥1).
- `COLOR`, 3'b111: RGB value driven for a lit pixel.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `rd_en`  out  1  frame-buffer read strobe, one cycle.
- `rd_row`  out  6  frame row requested (0..63).
- `rd_data`  in  64  row word; bit c = pixel at column c; valid exactly 1 clk after rd_en.
- `rgb1`  out  3  upper-half pixel (row addr).
- `rgb2`  out  3  lower-half pixel (row addr+32).
- `pclk`  out  1  panel shift clock.
- `lat`  out  1  panel latch strobe.
- `oe_n`  out  1  panel output enable, active-low.
- `addr`  out  5  panel scan-row address.
- `frame_start`  out  1  one-cycle pulse at start of row-0 fetch.
- `frame_done`  out  1  one-cycle pulse at end of row-31 SHOW.

## Operation
- Scan row r = 0..31 repeats forever, then wraps to 0. Each row passes through FETCH_U → FETCH_L → SHIFT → BLANK → LATCH → SHOW.
- FETCH_U (1 cycle): rd_en=1, rd_row=r; frame_start=1 when r=0.
- FETCH_L (1 cycle): capture upper word; rd_en=1, rd_row=r+32.
- FETCH_L exit (1 cycle, state WAIT_L): capture lower word. Fetch total is 3 cycles.
- SHIFT: 64 pixel slots, columns 63 down to 0, each 2*CLK_DIV cycles.
  - Each slot: rgb1/rgb2 = COLOR or 0 from upper/lower word bit, with pclk low for CLK_DIV cycles.
  - Then pclk high for CLK_DIV cycles, with data held stable.
  - The 64th rising edge carries column 0.
- BLANK (1 cycle): oe_n=1, addr←r, pclk=0, rgb=0.
- LATCH (1 cycle): lat=1.
- SHOW (ON_CYCLES cycles): oe_n=0, lat=0.
  - frame_done=1 on the last SHOW cycle when r=31.
  - Then r←r+1 (5-bit wrap).
- Outside SHOW, oe_n=1; outside SHIFT, rgb1=rgb2=0 and pclk=0.
- Pixel/slot counters are exact-width: column 6 bits, divider ⌈log2(CLK_DIV)⌉+1, on-time ⌈log2(ON_CYCLES)⌉+1. No overflow reachable.
- rd_data is sampled only in the cycle after its rd_en; other values are ignored.

## Timing
- Reset values: rd_en=0, rd_row=0, rgb1=rgb2=0, pclk=0, lat=0, oe_n=1, addr=0, frame_start=0, frame_done=0, state FETCH_U, r=0.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous); the panel blanks at once.
- First clk edge after reset release: rd_en=1, rd_row=0, frame_start=1.
- Row period = 3 + 128*CLK_DIV + 2 + ON_CYCLES clk cycles. Defaults: 517. Frame = 32 rows = 16544 cycles.
- All outputs are registered; no combinational input→output path.
- The frame buffer may change at any time. Each half-row is sampled exactly once per scan, at fetch.

## Configuration
- `LED_SCAN_TEST_EN` defined:
  - Adds input `test_en` (1 bit), sampled at FETCH_U.
  - When high, no rd_en is issued for that row; fetch states still take 3 cycles.
  - Words are replaced by a checkerboard: pixel = (column ^ frame_row) bit 0.
- Undefined: no `test_en` port; every row is read from the frame buffer.

## Structure
- Shared package `led_pkg`:
  - panel constants: WIDTH=64, HEIGHT=64, SCAN_ROWS=32.
  - scan state enum: FETCH_U, FETCH_L, WAIT_L, SHIFT, BLANK, LATCH, SHOW.
  - rgb_t (3-bit) typedef.
- One sub-module, `led_row_shifter`:
  - holds the two 64-bit row words and the column counter.
  - on a slot-advance strobe, presents the current column bits and decrements.
  - flags column-0 done.
- The FSM, divider and on-time counter stay in led_scan.

## Test plan
- Reset: hold rst → oe_n=1, all else 0. Release → next edge rd_en=1 rd_row=0 frame_start=1; next edge rd_en=1 rd_row=32.
- Single pixel: only row 0 bit 5 set → during row 0 SHIFT, rgb1=3'b111 at 59th pclk rising edge only; rgb2 always 0; addr=0 at latch.
- Lower half: only row 40 bit 0 set → during scan row 8, rgb2=3'b111 at 64th pclk edge; addr=8; rgb1 0.
- Cadence, defaults:
  - lat pulses exactly 517 cycles apart; oe_n low exactly 256 consecutive cycles per row.
  - addr 0..31 then wraps to 0; frame_done 16544 cycles after first frame_start.
- Reset mid-SHOW at row 12: oe_n=1 in the same cycle; after release, rd_row=0 and frame_start=1.
- With LED_SCAN_TEST_EN and test_en=1: no rd_en for a full frame; row 0 shifts alternating 1,0,… starting column 63=1; row 1 inverted.
